// File: rtl/slot_display_if.sv
// slot_display_if: result/flag inputs and display outputs of the slot display.
// Signals:
//   value   [9:0]  binary result to show (0..1023)
//   won            win flag, blinks the display while high
//   seg     [6:0]  active-low segments {g,f,e,d,c,b,a}
//   an      [3:0]  active-low one-hot digit enables, an[0] = ones digit
//   won_led        registered copy of won
//   busy           high while a conversion is in progress
interface slot_display_if;
   logic [9:0] value;
   logic       won;
   logic [6:0] seg;
   logic [3:0] an;
   logic       won_led;
   logic       busy;
   modport master (output value, won, input seg, an, won_led, busy);
   modport slave  (input value, won, output seg, an, won_led, busy);
endinterface

// File: rtl/slot_display.sv
// slot_display: double-dabble BCD conversion driving a scanned, blinkable 4-digit 7-seg display.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   io   slot_display_if.slave (value, won in; seg, an, won_led, busy out)
// Parameters:
//   SCAN_DIV   clk cycles each digit stays enabled (>=2)
//   BLINK_DIV  clk cycles per blink half-period while won is high (>=2)
// Build option:
//   SLOT_DISPLAY_LZB_EN  when defined, blanks leading zero digits (ones digit never blanked)
module slot_display #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 5000000
) (
   input logic           clk,
   input logic           rst,
   slot_display_if.slave io
);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
   state_t        r_state, w_state_n;
   logic [9:0]    r_cap, r_sh, r_last;
   logic [15:0]   r_bcd, r_disp, w_adj;
   logic [25:0]   w_shift;
   logic [3:0]    r_it;
   logic [SW-1:0] r_scan;
   logic [BW-1:0] r_bcnt;
   logic [1:0]    r_idx;
   logic          r_phase;
   logic [3:0]    w_dig;
   logic          w_blank;
   logic [6:0]    w_seg;
   logic [6:0]    r_seg;
   logic [3:0]    r_an;
   logic          r_won_led;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_n;

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE:  if (io.value != r_last) w_state_n = S_SHIFT;
         S_SHIFT: if (r_it == 4'd9) w_state_n = S_DONE;
         default: w_state_n = S_IDLE;
      endcase
   end

   // add-3 correction on every nibble that would overflow past 9 after the shift
   always_comb begin
      w_adj = r_bcd;
      for (int k = 0; k < 4; k++)
         if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
   end

   assign w_shift = {w_adj, r_sh} << 1;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_cap  <= '0;
         r_sh   <= '0;
         r_last <= '0;
         r_bcd  <= '0;
         r_disp <= '0;
         r_it   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (io.value != r_last) begin
               r_cap <= io.value;
               r_sh  <= io.value;
               r_bcd <= '0;
               r_it  <= '0;
            end
            S_SHIFT: begin
               r_bcd <= w_shift[25:10];
               r_sh  <= w_shift[9:0];
               r_it  <= r_it + 4'd1;
            end
            default: begin
               r_disp <= r_bcd;
               r_last <= r_cap;
            end
         endcase
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_scan <= '0;
         r_idx  <= '0;
      end else if (r_scan == SW'(SCAN_DIV - 1)) begin
         r_scan <= '0;
         r_idx  <= r_idx + 2'd1;
      end else begin
         r_scan <= r_scan + 1'b1;
      end

   // blink state only runs while won is high and collapses to phase 0 as soon as it drops
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_bcnt  <= '0;
         r_phase <= 1'b0;
      end else if (!io.won) begin
         r_bcnt  <= '0;
         r_phase <= 1'b0;
      end else if (r_bcnt == BW'(BLINK_DIV - 1)) begin
         r_bcnt  <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_bcnt <= r_bcnt + 1'b1;
      end

   assign w_dig = r_disp[{r_idx, 2'b00} +: 4];

`ifdef SLOT_DISPLAY_LZB_EN
   // a digit is blank when it and every higher digit are zero
   assign w_blank = (r_idx == 2'd3 && r_disp[15:12] == 4'd0) ||
                    (r_idx == 2'd2 && r_disp[15:8] == 8'd0) ||
                    (r_idx == 2'd1 && r_disp[15:4] == 12'd0);
`else
   assign w_blank = 1'b0;
`endif

   always_comb begin
      w_seg = 7'b1111111;
      if (!w_blank)
         case (w_dig)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
         endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_seg     <= 7'b1000000;
         r_an      <= 4'b1110;
         r_won_led <= 1'b0;
      end else begin
         r_seg     <= w_seg;
         r_an      <= (io.won && r_phase) ? 4'b1111 : ~(4'b0001 << r_idx);
         r_won_led <= io.won;
      end

   assign io.seg     = r_seg;
   assign io.an      = r_an;
   assign io.won_led = r_won_led;
   assign io.busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_slot_display.sv
// tb_slot_display: randomized scoreboard bench for slot_display (SCAN_DIV=4, BLINK_DIV=8).
module tb_slot_display;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   slot_display_if io();
   slot_display #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (.clk(clk), .rst(rst), .io(io));

   int checks = 0;
   int errors = 0;
   int q[$];
   int cur = 0;
   int pend = 0;
   bit has_pend = 1'b0;
   int bcnt = 0;
   int k = 0;
   int wj = 0;
   int exp_idx = 0;
   logic [3:0] exp_an = 4'b1110;
   logic exp_wl = 1'b0;
   int last_val = 0;

   function automatic logic [6:0] seg_of(int v, int d);
      int p;
      int dig;
      p = (d == 0) ? 1 : (d == 1) ? 10 : (d == 2) ? 100 : 1000;
      dig = (v / p) % 10;
`ifdef SLOT_DISPLAY_LZB_EN
      if (d > 0 && v < p) return 7'b1111111;
`endif
      case (dig)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // reference timing: digit index from edges since reset, blink phase from consecutive won edges
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         k = 0;
         wj = 0;
         exp_idx = 0;
         exp_an = 4'b1110;
         exp_wl = 1'b0;
      end else begin
         exp_idx = (k / 4) % 4;
         exp_an = (io.won && ((wj / 8) % 2 == 1)) ? 4'b1111 : ~(4'b0001 << exp_idx);
         exp_wl = io.won;
         wj = io.won ? wj + 1 : 0;
         k++;
      end
   end

   // monitor: a busy fall marks a finished conversion; the new value is on seg one cycle later
   initial forever begin
      @(negedge clk);
      if (rst) begin
         cur = 0;
         has_pend = 1'b0;
         bcnt = 0;
         chk("busy_rst", 32'(io.busy), 32'd0);
      end else if (has_pend) begin
         cur = pend;
         has_pend = 1'b0;
      end
      chk("an", 32'(io.an), 32'(exp_an));
      chk("won_led", 32'(io.won_led), 32'(exp_wl));
      if (exp_an != 4'b1111) chk($sformatf("seg_d%0d_v%0d", exp_idx, cur), 32'(io.seg), 32'(seg_of(cur, exp_idx)));
      if (!rst) begin
         if (io.busy) bcnt++;
         else if (bcnt != 0) begin
            chk("busy_len", 32'(bcnt), 32'd11);
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL conv_unexpected at %0t: got a conversion expected none", $time);
            end else begin
               pend = q.pop_front();
               has_pend = 1'b1;
            end
            bcnt = 0;
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_val(int v);
      io.value = v[9:0];
      q.push_back(v);
      last_val = v;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((io.busy || q.size() != 0 || has_pend) && t < 300) begin
         cyc(1);
         t++;
      end
      if (t >= 300) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout at %0t: got busy after %0d cycles expected idle", $time, t);
      end
   endtask

   initial begin
      int v;
      int v2;
      io.value = '0;
      io.won = 1'b0;
      #1 rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(20);
      set_val(1023);
      wait_idle();
      cyc(20);
      set_val(7);
      wait_idle();
      cyc(20);
      io.won = 1'b1;
      cyc(40);
      io.won = 1'b0;
      cyc(20);
      set_val(5);
      cyc(3);
      set_val(999);
      wait_idle();
      cyc(20);
      set_val(512);
      cyc(4);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      wait_idle();
      cyc(20);
      for (int i = 0; i < 15; i++) begin
         do v = int'($urandom_range(0, 1023)); while (v == last_val);
         io.won = ($urandom_range(0, 2) == 0);
         set_val(v);
         if ($urandom_range(0, 2) == 0) begin
            cyc(int'($urandom_range(1, 8)));
            do v2 = int'($urandom_range(0, 1023)); while (v2 == v);
            set_val(v2);
         end
         wait_idle();
         cyc(20);
      end
      io.won = 1'b0;
      cyc(20);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/slot_display.md
Name: slot_display

Overview:
- Downstream consumer of the mode3 reel stage.
- Takes mode3's 10-bit result `out` and `won` flag.
- Converts the binary result to 4 BCD digits with a sequential double-dabble engine, then drives a time-multiplexed 4-digit active-low seven-segment display.
- Blinks the whole display while `won` is high.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays enabled (≥2).
- BLINK_DIV, 5000000, clk cycles per blink half-period while won=1 (≥2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- value  input  10  binary result from mode3 `out`, 0..1023
- won  input  1  win flag from mode3
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
- an  output  4  digit enables, active-low one-hot, an[0]=ones digit, registered
- won_led  output  1  registered copy of won
- busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (async, rst=1), all state cleared:
  - seg=7'b1000000 ("0"), an=4'b1110, won_led=0, busy=0.
  - Display BCD regs=0, last-converted value=0, FSM=S_IDLE, scan/blink counters=0, blink phase=0.
- Conversion FSM:
  - S_IDLE:
    - If value != last-converted: capture value into shift reg, clear BCD scratch to 0, iteration count=0, go S_SHIFT, busy=1 from the next cycle.
    - Otherwise stay in S_IDLE.
  - S_SHIFT, one iteration per cycle, exactly 10 cycles:
    - Each BCD nibble ≥5 gets +3.
    - Then {bcd[15:0], shreg} shifts left by 1.
    - After the 10th iteration go S_DONE.
  - S_DONE:
    - Copy scratch into display BCD regs; last-converted=captured value.
    - busy=0; go S_IDLE.
  - Latency: a change seen in S_IDLE at cycle N appears in the display regs at the end of cycle N+11.
  - value is sampled only in S_IDLE. Changes during S_SHIFT/S_DONE are ignored, then picked up by the next S_IDLE compare, which reconverts. There is no lost final value.
  - Max input 1023 → digits 1,0,2,3. No overflow is possible with 4 digits.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - On wrap, digit index advances 0→1→2→3→0.
  - an/seg registered, one cycle after the index changes.
  - an[idx]=0, others=1. seg = decode of display digit idx.
- Decode (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other nibble=1111111.
- Blink:
  - won_led <= won every cycle.
  - While won=1: blink_cnt counts 0..BLINK_DIV-1; on wrap, blink phase toggles.
  - While phase=1: an forced to 4'b1111. Scan keeps running underneath.
  - When won=0: blink_cnt and phase clear synchronously next cycle; normal scan output resumes the same cycle.
- Simultaneous value change and won rise: independent. Conversion proceeds while blinking.
- Reset mid-conversion: scratch discarded, display shows 0. After release, the S_IDLE compare reconverts the current value (if nonzero).

Optional Feature:
- Macro: SLOT_DISPLAY_LZB_EN.
- Defined: leading-zero blanking.
  - Digits above the most significant nonzero digit output seg=7'b1111111.
  - The ones digit is never blanked; value 0 shows a single "0".
  - The blanking decision uses the display regs (post-conversion values), not the scratch.
- Undefined: all four digits are always decoded, leading zeros shown as "0".

Test Plan (SCAN_DIV=4, BLINK_DIV=8):
1. Reset:
   - Stimulus: rst=1 for 3 cycles, value=0, won=0.
   - Required: seg=1000000, an=1110, busy=0, won_led=0. After release, an rotates 1110→1101→1011→0111 every 4 cycles.
2. Max value:
   - Stimulus: value=1023.
   - Required: busy=1 for exactly 11 cycles. Then the scan shows seg=0110000 (an=1110), 0100100 (1101), 1000000 (1011), 1111001 (0111).
3. Small value:
   - Stimulus: value=7.
   - Required with SLOT_DISPLAY_LZB_EN: digits 1–3 seg=1111111, digit 0 seg=1111000.
   - Required without: digits 1–3 seg=1000000.
4. Blink:
   - Stimulus: won=1 for 40 cycles.
   - Required: won_led=1 one cycle later; an alternates scanning / 1111 every 8 cycles.
   - Stimulus: won=0.
   - Required: scanning resumes the next cycle, phase=0.
5. Mid-conversion change:
   - Stimulus: value=5, then value=999 at the 3rd S_SHIFT cycle.
   - Required: display first shows 0005, then busy reasserts and the display shows 0999 after a second 11-cycle conversion.
6. Reset mid-conversion:
   - Stimulus: value=512, assert rst during S_SHIFT.
   - Required: outputs return to reset values immediately; after release, 512 converts and is displayed.
